// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the RV64 memory-access stage.
// Bus types, operation encoding, size masks and the EX/MEM and MEM/WB records.
// The mem_wb record always carries a misalign flag; it can only be set when
// MEM_MISALIGN_CHECK_EN is defined.
package mem_access_pkg;

    localparam int XLEN = 64;

    // Operations seen by the memory stage. Only the load/store group touches the bus.
    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD
    } op_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Byte-lane masks for an aligned access of each size, before shifting by the offset.
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
        msize_t          size;
        logic [7:0]      strobe;
        logic [XLEN-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] inst_pc;
        op_t             op;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2_data;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     inst;
        logic [XLEN-1:0] inst_pc;
        op_t             op;
        logic [XLEN-1:0] value;
        logic            misalign;
    } mem_wb_t;

    function automatic logic is_load(op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
    endfunction

    function automatic logic is_store(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
    endfunction

    function automatic logic is_mem(op_t op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic load_signed(op_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic msize_t op_size(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MSIZE1;
            OP_LH, OP_LHU, OP_SH: return MSIZE2;
            OP_LW, OP_LWU, OP_SW: return MSIZE4;
            default:              return MSIZE8;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_bits(msize_t s);
        case (s)
            MSIZE1:  return 3'b000;
            MSIZE2:  return 3'b001;
            MSIZE4:  return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: bundles the memory stage's pipeline records and data bus.
// master = the memory stage, slave = its surroundings (pipeline + bus).
interface mem_access_if;
    import mem_access_pkg::*;

    ex_mem_t    ex_mem_state;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_wb_t    mem_wb_state;
    logic       stall;

    modport master (
        input  ex_mem_state, dresp,
        output dreq, mem_wb_state, stall
    );

    modport slave (
        output ex_mem_state, dresp,
        input  dreq, mem_wb_state, stall
    );
endinterface

// File: rtl/mem_align.sv
// mem_align: combinational byte-lane steering for the memory stage.
// Store side: strobe and data shifted to the addressed lanes.
// Load side: addressed bytes moved to bit 0, truncated and sign/zero-extended.
module mem_align
    import mem_access_pkg::*;
(
    input  msize_t      size_i,
    input  logic [2:0]  off_i,
    input  logic        sign_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  strobe_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);
    logic [7:0]  mask;
    logic [63:0] shifted;

    // Lane steering for both directions; offsets are byte granular.
    always_comb begin
        case (size_i)
            MSIZE1:  mask = MASK_B;
            MSIZE2:  mask = MASK_H;
            MSIZE4:  mask = MASK_W;
            default: mask = MASK_D;
        endcase
        strobe_o = mask << off_i;
        wdata_o  = wdata_i << {off_i, 3'b000};
        shifted  = rdata_i >> {off_i, 3'b000};
        case (size_i)
            MSIZE1:  rdata_o = {{56{sign_i & shifted[7]}},  shifted[7:0]};
            MSIZE2:  rdata_o = {{48{sign_i & shifted[15]}}, shifted[15:0]};
            MSIZE4:  rdata_o = {{32{sign_i & shifted[31]}}, shifted[31:0]};
            default: rdata_o = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV64 pipeline.
// Two-state request FSM holds the pipeline until the bus returns data_ok and
// then registers the mem_wb record. Non-memory ops pass through in one cycle.
// Optional: MEM_MISALIGN_CHECK_EN turns misaligned accesses into a flagged,
// bus-less one-cycle completion carrying the faulting address.
module mem_access
    import mem_access_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mem_access_if.master  bus
);
    state_t      state_q, state_d;
    logic [63:0] addr_q;
    msize_t      size_q;
    logic [7:0]  strobe_q;
    logic [63:0] data_q;
    op_t         op_q;
    mem_wb_t     mem_wb_q, mem_wb_d;

    ex_mem_t     ex;
    dbus_req_t   dreq_c;
    logic        stall_c;
    logic        ex_is_mem;
    logic        ex_misalign;
    logic        issue;

    op_t         cur_op;
    logic [2:0]  cur_off;
    logic [7:0]  st_strobe;
    logic [63:0] st_data;
    logic [63:0] ld_value;

    assign ex        = bus.ex_mem_state;
    assign ex_is_mem = ex.valid && is_mem(ex.op);

`ifdef MEM_MISALIGN_CHECK_EN
    assign ex_misalign = ex_is_mem &&
                         ((ex.alu_result[2:0] & align_bits(op_size(ex.op))) != 3'b000);
`else
    assign ex_misalign = 1'b0;
`endif

    assign issue = (state_q == S_IDLE) && ex_is_mem && !ex_misalign;

    // While waiting, the latched request defines which lanes the response uses.
    assign cur_op  = (state_q == S_WAIT) ? op_q : ex.op;
    assign cur_off = (state_q == S_WAIT) ? addr_q[2:0] : ex.alu_result[2:0];

    mem_align u_align (
        .size_i   (op_size(cur_op)),
        .off_i    (cur_off),
        .sign_i   (load_signed(cur_op)),
        .wdata_i  (ex.rs2_data),
        .rdata_i  (bus.dresp.data),
        .strobe_o (st_strobe),
        .wdata_o  (st_data),
        .rdata_o  (ld_value)
    );

    // Request FSM: issue from ex_mem in IDLE, replay latched request in WAIT.
    always_comb begin
        state_d = state_q;
        dreq_c  = '0;
        stall_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    dreq_c.valid  = 1'b1;
                    dreq_c.addr   = ex.alu_result;
                    dreq_c.size   = op_size(ex.op);
                    dreq_c.strobe = is_store(ex.op) ? st_strobe : 8'h00;
                    dreq_c.data   = is_store(ex.op) ? st_data : 64'h0;
                    if (!bus.dresp.data_ok) begin
                        state_d = S_WAIT;
                        stall_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                dreq_c.valid  = 1'b1;
                dreq_c.addr   = addr_q;
                dreq_c.size   = size_q;
                dreq_c.strobe = strobe_q;
                dreq_c.data   = data_q;
                if (bus.dresp.data_ok) begin
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset kills the outstanding request on the bus immediately, not at the next edge.
    assign bus.dreq  = reset ? '0 : dreq_c;
    assign bus.stall = ~reset & stall_c;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Latch the request on issue so it stays constant while the bus is slow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            size_q   <= MSIZE1;
            strobe_q <= '0;
            data_q   <= '0;
            op_q     <= OP_NOP;
        end else if (issue) begin
            addr_q   <= dreq_c.addr;
            size_q   <= dreq_c.size;
            strobe_q <= dreq_c.strobe;
            data_q   <= dreq_c.data;
            op_q     <= ex.op;
        end
    end

    // Writeback record: bubble while stalled, otherwise capture the completing instruction.
    always_comb begin
        mem_wb_d       = mem_wb_q;
        mem_wb_d.valid = 1'b0;
        if (!stall_c) begin
            mem_wb_d.valid    = ex.valid;
            mem_wb_d.inst     = ex.inst;
            mem_wb_d.inst_pc  = ex.inst_pc;
            mem_wb_d.op       = ex.op;
            mem_wb_d.value    = (is_load(ex.op) && !ex_misalign) ? ld_value : ex.alu_result;
            mem_wb_d.misalign = ex_misalign;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_wb_q <= '0;
        else       mem_wb_q <= mem_wb_d;
    end

    assign bus.mem_wb_state = mem_wb_q;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage RV64 pipeline, between the EX/MEM register and the writeback stage. Loads and stores drive the data bus through a two-state request FSM that holds the pipeline until the bus returns `data_ok`. Store data and byte strobes are aligned, and load data is extracted and sign/zero-extended. The stage registers the `mem_wb` record that writeback consumes combinationally; non-memory instructions pass through in one cycle.

## Interface
Parameters: none. Widths come from `common` (64-bit XLEN).
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `ex_mem_state`  in  `ex_mem`  upstream record: `valid`, `inst`, `inst_pc`, `op`, `alu_result[63:0]`, `rs2_data[63:0]`. Held stable by upstream while `stall`=1.
- `dreq`  out  `dbus_req`  `valid`, `addr[63:0]`, `size` (`msize_t`), `strobe[7:0]`, `data[63:0]`.
- `dresp`  in  `dbus_resp`  `data_ok`, `data[63:0]`.
- `mem_wb_state`  out  `mem_wb`  registered record: `valid`, `inst`, `inst_pc`, `op`, `value[63:0]`, plus `misalign` when configured.
- `stall`  out  1  freezes IF..EX and the EX/MEM register.

## Operation
- Memory op: `op` ∈ {LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD}. Address = `alu_result`; `off` = addr[2:0].
- FSM states:
  - IDLE: if `ex_mem.valid` and memory op, drive `dreq` from `ex_mem` and latch `addr/size/strobe/data/op` into request registers.
    - If `data_ok` arrives the same cycle, complete and stay IDLE.
    - Otherwise go to WAIT.
  - WAIT: drive `dreq` from the latched registers. On `data_ok`, complete and return to IDLE.
- `dreq.valid` stays high and all `dreq` fields stay constant from issue until the cycle of `data_ok` inclusive. It drops the cycle after completion unless a new memory op is present.
- Store data and strobe:
  - `strobe` = size mask (0x01/0x03/0x0F/0xFF) << `off`.
  - `data` = `rs2_data` << (8·`off`).
- Load value: `dresp.data` >> (8·`off`), truncated to the access size. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU/LD.
- `mem_wb.value`:
  - loads: the extended load value;
  - stores and non-memory ops: `alu_result`.
- `stall` = memory op pending and `data_ok`=0. It is combinational, so it is high in the issue cycle when `data_ok` is absent.
- On completion, or every cycle for a non-memory op:
  - `mem_wb` captures `valid`, `inst`, `inst_pc`, `op` and `value`.
  - While stalled, `mem_wb.valid` is written 0 (bubble), so writeback never commits twice.
- Invalid `ex_mem` (`valid`=0): registers a bubble and issues no request.

## Timing
- Reset values (asynchronous):
  - state = IDLE;
  - `dreq.valid`=0 with all `dreq` fields 0;
  - `mem_wb_state` all-zero with `valid`=0;
  - `stall`=0, except that `stall` is combinational and may rise once reset deasserts.
- Latency: non-memory op, 1 cycle. Memory op, issue cycle through `data_ok` cycle, then `mem_wb` valid on the next edge. The minimum is 1 cycle with a zero-wait bus.
- Reset mid-transaction: the request is abandoned, no `mem_wb` is produced, and a late `data_ok` arriving in IDLE with no pending op is ignored.
- `data_ok` back-to-back: a new op may issue in the cycle after completion; there are no idle cycles between them.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - An access with addr not a multiple of its size (e.g. LW at off=2, LD at off≠0) issues no bus request and does not stall.
  - It completes in 1 cycle with `mem_wb.misalign`=1 and `value`=faulting address.
- Undefined: the `misalign` field is tied 0 and no check is made. Accesses that cross the 8-byte boundary are undefined.

## Structure
- `common`: the `op` enum, `msize_t`, `dbus_req`/`dbus_resp` structs, and the size-mask constants.
- `temp_storage`: `ex_mem` and `mem_wb`, with `misalign` under the macro.
- Sub-module `mem_align`, combinational, for store shift/strobe generation and load extract/extend. It is reused by the bus model in the bench.
- The FSM and pipeline register stay in `mem_access`.

## Test plan
- ADD with `alu_result`=0x1234, `valid`=1 → next cycle `mem_wb.value`=0x1234, `valid`=1; `stall` never high; `dreq.valid`=0.
- SB with addr 0x80000003, `rs2_data`=0xAB, bus `data_ok` after 3 cycles → `strobe`=0x08, `data`=0xAB000000 held stable 4 cycles; `stall` high 3 cycles; `mem_wb.valid` high once.
- LB at 0x80000005, `dresp.data`=0x0000_80FF_0000_0000 → `value`=0xFFFF_FFFF_FFFF_FF80. LBU at the same address → `value`=0x80.
- LW at 0x80000004 with zero-wait `data_ok`, followed by LD at 0x80000008 → both complete on consecutive cycles; `stall`=0 throughout.
- Reset pulse in WAIT → `dreq.valid`=0 and `mem_wb.valid`=0 immediately; a later stray `data_ok` produces no commit.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x80000002 → `dreq.valid` stays 0; next cycle `misalign`=1, `value`=0x80000002.
